// File: rtl/hilo_pkg.sv
// Purpose: shared op codes, FSM encoding and sizing helpers for the HI/LO mul/div unit.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package hilo_pkg;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MADD  = 3'd4;
  localparam logic [2:0] OP_MSUB  = 3'd5;
  localparam logic [2:0] OP_MTHI  = 3'd6;
  localparam logic [2:0] OP_MTLO  = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2
  } state_t;

  // Step counter runs WIDTH-1 down to 0.
  function automatic int cnt_width(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

  function automatic logic is_div_op(input logic [2:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  // MADD/MSUB accumulate a signed product.
  function automatic logic is_signed_op(input logic [2:0] op);
    return (op == OP_MULT) || (op == OP_DIV) || (op == OP_MADD) || (op == OP_MSUB);
  endfunction

endpackage

// File: rtl/hilo_muldiv_unit_if.sv
// Purpose: request/result bundle between the EX/ID stages and the HI/LO mul/div unit.
// Latency: n/a (wiring only).
// Backpressure: busy blocks new starts; stall = busy & hilo_read.
// Ports: start/op/a/b/flush/hilo_read driven by the pipeline (master);
//        busy/done/stall/hi/lo driven by the unit (slave).
interface hilo_muldiv_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             flush;
  logic             hilo_read;
  logic             busy;
  logic             done;
  logic             stall;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b, flush, hilo_read,
    input  busy, done, stall, hi, lo
  );

  modport slave (
    input  start, op, a, b, flush, hilo_read,
    output busy, done, stall, hi, lo
  );
endinterface

// File: rtl/muldiv_sign_fix.sv
// Purpose: turn the unsigned magnitude result into final HI/LO (sign fix, MADD/MSUB accumulate).
// Latency: combinational.
// Backpressure: none.
// Ports: raw = {upper,lower} magnitude result, neg_p = product/quotient negative,
//        neg_r = remainder negative, op = operation, hi_in/lo_in = current HI/LO,
//        hi_out/lo_out = values to write.
module muldiv_sign_fix
  import hilo_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH-1:0] raw,
  input  logic               neg_p,
  input  logic               neg_r,
  input  logic [2:0]         op,
  input  logic [WIDTH-1:0]   hi_in,
  input  logic [WIDTH-1:0]   lo_in,
  output logic [WIDTH-1:0]   hi_out,
  output logic [WIDTH-1:0]   lo_out
);

  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] res;
  logic [WIDTH-1:0]   quo;
  logic [WIDTH-1:0]   rem;

  always_comb begin
    prod = neg_p ? -raw : raw;
    acc  = {hi_in, lo_in};
    // Divide result layout: remainder in the upper half, quotient in the lower half.
    // Negating the most negative quotient wraps back to itself, which is the wanted result.
    quo  = neg_p ? -raw[WIDTH-1:0] : raw[WIDTH-1:0];
    rem  = neg_r ? -raw[2*WIDTH-1:WIDTH] : raw[2*WIDTH-1:WIDTH];
    res  = acc;
    case (op)
      OP_MULT, OP_MULTU: res = prod;
      OP_MADD:           res = acc + prod;
      OP_MSUB:           res = acc - prod;
      OP_DIV, OP_DIVU:   res = {rem, quo};
      default:           res = acc;
    endcase
    hi_out = res[2*WIDTH-1:WIDTH];
    lo_out = res[WIDTH-1:0];
  end

endmodule

// File: rtl/hilo_muldiv_unit.sv
// Purpose: iterative radix-2 multiply/divide engine owning the HI/LO register pair.
// Latency: WIDTH+1 cycles for mul/div/madd/msub; 1 cycle for MTHI/MTLO and divide-by-zero.
// Backpressure: start ignored while busy (no queueing); stall = busy & hilo_read.
// Ports: clk, rst_n (async active-low); bus = hilo_muldiv_unit_if slave
//        (start/op/a/b/flush/hilo_read in, busy/done/stall/hi/lo out).
module hilo_muldiv_unit
  import hilo_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  hilo_muldiv_unit_if.slave bus
);

  localparam int            CW       = cnt_width(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opb_q, opb_d;
  logic [2:0]         op_q, op_d;
  logic               neg_p_q, neg_p_d;
  logic               neg_r_q, neg_r_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  // Request decode (only meaningful in IDLE; flush suppresses a same-cycle start).
  logic             start_ok, start_div, div_zero, start_iter, start_move;
  logic             neg_a, neg_b;
  logic [WIDTH-1:0] mag_a, mag_b;

  assign start_ok   = bus.start & ~bus.flush & (state_q == ST_IDLE);
  assign start_div  = is_div_op(bus.op);
  assign div_zero   = start_div & (bus.b == '0);
  assign start_iter = start_ok & (bus.op <= OP_MSUB) & ~div_zero;
  assign start_move = start_ok & ((bus.op == OP_MTHI) | (bus.op == OP_MTLO));
  assign neg_a      = is_signed_op(bus.op) & bus.a[WIDTH-1];
  assign neg_b      = is_signed_op(bus.op) & bus.b[WIDTH-1];
  assign mag_a      = neg_a ? -bus.a : bus.a;
  assign mag_b      = neg_b ? -bus.b : bus.b;

  // Multiply step: acc = {partial product, remaining multiplier bits}; add the
  // multiplicand into the upper half when the current multiplier LSB is set, then shift right.
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + ({(WIDTH+1){acc_q[0]}} & {1'b0, opb_q});
  assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

  // Restoring divide step: acc = {partial remainder, dividend/quotient bits}.
  // The shifted-in remainder needs WIDTH+1 bits before the trial subtract.
  logic [WIDTH:0]     div_part, div_trial;
  logic [WIDTH-1:0]   div_rem;
  logic [2*WIDTH-1:0] div_next;
  assign div_part  = acc_q[2*WIDTH-1:WIDTH-1];
  assign div_trial = div_part - {1'b0, opb_q};
  assign div_rem   = div_trial[WIDTH] ? div_part[WIDTH-1:0] : div_trial[WIDTH-1:0];
  assign div_next  = {div_rem, acc_q[WIDTH-2:0], ~div_trial[WIDTH]};

  logic [WIDTH-1:0] fix_hi, fix_lo;

  muldiv_sign_fix #(.WIDTH(WIDTH)) u_sign_fix (
    .raw    (acc_q),
    .neg_p  (neg_p_q),
    .neg_r  (neg_r_q),
    .op     (op_q),
    .hi_in  (hi_q),
    .lo_in  (lo_q),
    .hi_out (fix_hi),
    .lo_out (fix_lo)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      opb_q   <= '0;
      op_q    <= OP_MULT;
      neg_p_q <= 1'b0;
      neg_r_q <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      opb_q   <= opb_d;
      op_q    <= op_d;
      neg_p_q <= neg_p_d;
      neg_r_q <= neg_r_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start_iter) state_d = ST_CALC;
      ST_CALC: begin
        if (bus.flush)          state_d = ST_IDLE;
        else if (cnt_q == '0)   state_d = ST_FIX;
      end
      ST_FIX:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath and outputs.
  always_comb begin
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    opb_d   = opb_q;
    op_d    = op_q;
    neg_p_d = neg_p_q;
    neg_r_d = neg_r_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    busy_d  = (state_d != ST_IDLE);
    case (state_q)
      ST_IDLE: begin
        if (start_iter) begin
          cnt_d   = CNT_LAST;
          op_d    = bus.op;
          neg_p_d = neg_a ^ neg_b;
          neg_r_d = neg_a;
          if (start_div) begin
            opb_d = mag_b;
            acc_d = {{WIDTH{1'b0}}, mag_a};
          end else begin
            opb_d = mag_a;
            acc_d = {{WIDTH{1'b0}}, mag_b};
          end
        end else if (start_move) begin
          if (bus.op == OP_MTHI) hi_d = bus.a;
          else                   lo_d = bus.a;
          done_d = 1'b1;
        end else if (start_ok && div_zero) begin
          hi_d   = bus.a;
          lo_d   = '1;
          done_d = 1'b1;
        end
      end
      ST_CALC: begin
        if (!bus.flush) begin
          cnt_d = (cnt_q == '0) ? '0 : cnt_q - 1'b1;
          acc_d = is_div_op(op_q) ? div_next : mul_next;
        end
      end
      ST_FIX: begin
        if (!bus.flush) begin
          hi_d   = fix_hi;
          lo_d   = fix_lo;
          done_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.hi    = hi_q;
  assign bus.lo    = lo_q;
  assign bus.stall = busy_q & bus.hilo_read;

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
module tb_hilo_muldiv_unit;
  import hilo_pkg::*;

  logic clk;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;
  logic [31:0] m_hi = 32'h0;
  logic [31:0] m_lo = 32'h0;

  hilo_muldiv_unit_if #(.WIDTH(32)) bus ();

  hilo_muldiv_unit #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Architectural reference: 64-bit arithmetic on the 32-bit operands.
  function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                        input logic [31:0] hi, input logic [31:0] lo);
    longint      sa, sb;
    logic [63:0] acc;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    acc = {hi, lo};
    case (op)
      3'd0: return 64'(sa * sb);
      3'd1: return {32'h0, a} * {32'h0, b};
      3'd2: if (b == 32'h0) return {a, 32'hFFFF_FFFF};
            else return {32'(sa % sb), 32'(sa / sb)};
      3'd3: if (b == 32'h0) return {a, 32'hFFFF_FFFF};
            else return {a % b, a / b};
      3'd4: return acc + 64'(sa * sb);
      3'd5: return acc - 64'(sa * sb);
      3'd6: return {a, lo};
      default: return {hi, a};
    endcase
  endfunction

  // Issue one operation and follow it to completion, checking latency,
  // the Done cycle contents, stall behaviour and the idle cycle after.
  task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input bit rd, input bit poke, input string tag);
    logic [63:0] expv;
    int          n;
    bit          iter;
    bit          busy_ok;
    expv = model(op, a, b, m_hi, m_lo);
    iter = (op <= 3'd5) && !((op == 3'd2 || op == 3'd3) && b == 32'h0);
    bus.op        = op;
    bus.a         = a;
    bus.b         = b;
    bus.start     = 1'b1;
    bus.hilo_read = rd;
    tick;
    bus.start = 1'b0;
    n = 0;
    busy_ok = 1'b1;
    while (bus.busy === 1'b1 && n < 100) begin
      if (bus.stall !== rd)     busy_ok = 1'b0;
      if (bus.done !== 1'b0)    busy_ok = 1'b0;
      if (poke && n == 5) begin
        bus.start = 1'b1;
        bus.op    = OP_MTHI;
        bus.a     = 32'hDEAD_BEEF;
      end
      n++;
      tick;
      bus.start = 1'b0;
    end
    chk({tag, ".busy_cycles"}, 64'(n), iter ? 64'd33 : 64'd0);
    if (iter) chk({tag, ".busy_phase"}, {63'h0, busy_ok}, 64'h1);
    chk({tag, ".done"}, {63'h0, bus.done}, 64'h1);
    chk({tag, ".stall_done"}, {63'h0, bus.stall}, 64'h0);
    chk({tag, ".hilo"}, {bus.hi, bus.lo}, expv);
    m_hi = expv[63:32];
    m_lo = expv[31:0];
    bus.hilo_read = 1'b0;
    tick;
    chk({tag, ".after"}, {31'h0, bus.done, bus.hi, bus.lo}, {31'h0, 1'b0, m_hi, m_lo});
  endtask

  initial begin
    logic [2:0]  rop;
    logic [31:0] ra, rb;

    rst_n         = 1'b0;
    bus.start     = 1'b0;
    bus.op        = 3'd0;
    bus.a         = 32'h0;
    bus.b         = 32'h0;
    bus.flush     = 1'b0;
    bus.hilo_read = 1'b1;
    #12;
    chk("reset.busy",  {63'h0, bus.busy},  64'h0);
    chk("reset.done",  {63'h0, bus.done},  64'h0);
    chk("reset.stall", {63'h0, bus.stall}, 64'h0);
    chk("reset.hilo",  {bus.hi, bus.lo},   64'h0);
    bus.hilo_read = 1'b0;
    rst_n = 1'b1;
    tick;

    // Directed scenarios.
    do_op(OP_MULT,  32'hFFFF_FFFF, 32'd3, 1'b1, 1'b0, "mult");
    chk("mult.const", {bus.hi, bus.lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    do_op(OP_MULTU, 32'hFFFF_FFFF, 32'd3, 1'b0, 1'b1, "multu");
    chk("multu.const", {bus.hi, bus.lo}, 64'h0000_0002_FFFF_FFFD);
    do_op(OP_MADD,  32'd1, 32'd1, 1'b0, 1'b0, "madd");
    chk("madd.const", {bus.hi, bus.lo}, 64'h0000_0002_FFFF_FFFE);
    do_op(OP_MSUB,  32'hFFFF_FFFE, 32'd5, 1'b0, 1'b0, "msub");
    do_op(OP_DIV,   32'hFFFF_FFF9, 32'd2, 1'b1, 1'b0, "div_neg");
    chk("div_neg.const", {bus.hi, bus.lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    do_op(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, "div_min");
    chk("div_min.const", {bus.hi, bus.lo}, 64'h0000_0000_8000_0000);
    do_op(OP_DIVU,  32'hFFFF_FFF9, 32'd10, 1'b0, 1'b0, "divu");
    do_op(OP_DIVU,  32'd7, 32'd0, 1'b1, 1'b0, "divu_zero");
    chk("divu_zero.const", {bus.hi, bus.lo}, 64'h0000_0007_FFFF_FFFF);
    do_op(OP_DIV,   32'hFFFF_FF00, 32'd0, 1'b0, 1'b0, "div_zero");
    do_op(OP_MTLO,  32'h1234, 32'd0, 1'b0, 1'b0, "mtlo");
    chk("mtlo.const", {32'h0, bus.lo}, 64'h1234);

    // Flush mid-calculation.
    do_op(OP_MTHI, 32'h55, 32'd0, 1'b0, 1'b0, "set_hi");
    do_op(OP_MTLO, 32'h55, 32'd0, 1'b0, 1'b0, "set_lo");
    bus.op = OP_MULT; bus.a = 32'h1234_5678; bus.b = 32'h9ABC_DEF0; bus.start = 1'b1;
    tick;
    bus.start = 1'b0;
    repeat (9) tick;
    chk("flush.busy_before", {63'h0, bus.busy}, 64'h1);
    bus.flush = 1'b1;
    tick;
    bus.flush = 1'b0;
    chk("flush.state", {62'h0, bus.busy, bus.done}, 64'h0);
    chk("flush.hilo", {bus.hi, bus.lo}, 64'h0000_0055_0000_0055);
    repeat (40) begin
      if (bus.done !== 1'b0) chk("flush.late_done", {63'h0, bus.done}, 64'h0);
      tick;
    end
    chk("flush.quiet", {62'h0, bus.busy, bus.done}, 64'h0);

    // Flush beats a same-cycle start in IDLE.
    bus.op = OP_MTHI; bus.a = 32'h99; bus.start = 1'b1; bus.flush = 1'b1;
    tick;
    bus.start = 1'b0; bus.flush = 1'b0;
    chk("flush_start.state", {62'h0, bus.busy, bus.done}, 64'h0);
    chk("flush_start.hilo", {bus.hi, bus.lo}, 64'h0000_0055_0000_0055);

    // Reset mid-operation.
    bus.op = OP_MULTU; bus.a = 32'hFFFF_FFFF; bus.b = 32'hFFFF_FFFF; bus.start = 1'b1;
    tick;
    bus.start = 1'b0;
    repeat (10) tick;
    rst_n = 1'b0;
    #1;
    chk("rst_mid.hilo", {bus.hi, bus.lo}, 64'h0);
    chk("rst_mid.state", {62'h0, bus.busy, bus.done}, 64'h0);
    #2;
    rst_n = 1'b1;
    m_hi = 32'h0;
    m_lo = 32'h0;
    tick;
    chk("rst_mid.idle", {62'h0, bus.busy, bus.done}, 64'h0);

    // Randomized operations against the reference model.
    for (int i = 0; i < 40; i++) begin
      rop = 3'($urandom_range(7, 0));
      ra  = $urandom;
      case ($urandom_range(4, 0))
        0:       rb = 32'h0;
        1:       rb = 32'($urandom_range(15, 1));
        2:       rb = 32'hFFFF_FFFF;
        default: rb = $urandom;
      endcase
      if ($urandom_range(5, 0) == 0) ra = 32'h8000_0000;
      do_op(rop, ra, rb, 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)), "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
